// File: rtl/imem_sync.sv
// imem_sync: clocked instruction memory with a fetch handshake and a run-time load port.
//
// Stores DEPTH words of DW bits. A fetch accepted at clock edge N is looked up at edge N+1.
// The word then appears on out_o with a one-cycle out_valid_o pulse. Loads have strict
// priority, so fetch_ready_o drops while ld_en_i is high or during reset.
//
// Optional build macro: IMEM_BOOT_PROG_EN. When it is defined, reset also writes the boot
// program into words 0..8 and clears every other word. This build requires DW == 8 and
// DEPTH >= 9.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous, active-high reset
//   fetch_req_i    fetch request for the word at fetch_ad_i
//   fetch_ad_i     fetch address (AW bits)
//   fetch_ready_o  a fetch is accepted when fetch_req_i && fetch_ready_o
//   out_o          fetched word; holds its value between fetches
//   out_valid_o    one-cycle pulse when out_o carries a new word
//   fault_o        pulses with out_valid_o when the fetch address was >= DEPTH
//   ld_en_i        write ld_data_i to ld_ad_i at this edge
//   ld_ad_i        load address (AW bits)
//   ld_data_i      load data (DW bits)
//   ld_err_o       one-cycle pulse on the cycle after a load with ld_ad_i >= DEPTH
//   fetch_cnt_o    saturating count of accepted fetches; cleared only by reset
module imem_sync #(
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          fetch_req_i,
  input  logic [AW-1:0] fetch_ad_i,
  output logic          fetch_ready_o,
  output logic [DW-1:0] out_o,
  output logic          out_valid_o,
  output logic          fault_o,
  input  logic          ld_en_i,
  input  logic [AW-1:0] ld_ad_i,
  input  logic [DW-1:0] ld_data_i,
  output logic          ld_err_o,
  output logic [15:0]   fetch_cnt_o
);

  localparam int unsigned IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH may equal 2**AW, so the range compares need one extra bit.
  localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);

  if (DEPTH > (1 << AW)) begin : g_depth_chk
    $error("imem_sync: DEPTH must not exceed 2**AW");
  end

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   mem_q [DEPTH];
  logic [IW-1:0]   addr_q, addr_d;
  logic            oor_q, oor_d;
  logic [DW-1:0]   out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic            fault_q, fault_d;
  logic            ld_err_q, ld_err_d;
  logic [15:0]     cnt_q, cnt_d;

  logic            fetch_acc;
  logic            fetch_in_range;
  logic            ld_in_range;
  logic            ld_wr;
  logic            rd_en;

  assign fetch_ready_o  = !ld_en_i && !rst_i;
  assign fetch_acc      = fetch_req_i && fetch_ready_o;
  assign fetch_in_range = {1'b0, fetch_ad_i} < DepthW;
  assign ld_in_range    = {1'b0, ld_ad_i} < DepthW;
  assign ld_wr          = ld_en_i && ld_in_range;

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. IDLE and RESP both move to RESP on an accepted fetch and to IDLE otherwise.
  always_comb begin
    state_d = StIdle;
    if (fetch_acc) begin
      state_d = StResp;
    end
  end

  // FSM: outputs
  always_comb begin
    rd_en = 1'b0;
    unique case (state_q)
      StResp:  rd_en = 1'b1;
      default: rd_en = 1'b0;
    endcase
  end

  // Datapath next-state values
  always_comb begin
    addr_d      = addr_q;
    oor_d       = oor_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    fault_d     = 1'b0;
    cnt_d       = cnt_q;
    ld_err_d    = ld_en_i && !ld_in_range;
    if (fetch_acc) begin
      addr_d = fetch_ad_i[IW-1:0];
      oor_d  = !fetch_in_range;
      if (cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
    if (rd_en) begin
      out_valid_d = 1'b1;
      fault_d     = oor_q;
      // An out-of-range fetch returns zero without reading the memory array.
      out_d       = oor_q ? '0 : mem_q[addr_q];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q      <= '0;
      oor_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      ld_err_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      addr_q      <= addr_d;
      oor_q       <= oor_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      fault_q     <= fault_d;
      ld_err_q    <= ld_err_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef IMEM_BOOT_PROG_EN
  if (DW != 8 || DEPTH < 9) begin : g_boot_chk
    $error("imem_sync: IMEM_BOOT_PROG_EN requires DW == 8 and DEPTH >= 9");
  end

  // Opcode encodings used by the control unit: 3-bit opcode plus 5-bit operand.
  // Long instructions carry their sub-opcode in the operand field.
  localparam logic [2:0] CuLda       = 3'b001;
  localparam logic [2:0] CuAdd       = 3'b010;
  localparam logic [2:0] CuSta       = 3'b011;
  localparam logic [2:0] CuBan       = 3'b100;
  localparam logic [2:0] CuJmp       = 3'b101;
  localparam logic [2:0] CuLongBegin = 3'b111;
  localparam logic [4:0] CuCla       = 5'b00001;
  localparam logic [4:0] CuCsl       = 5'b00010;
  localparam logic [4:0] CuShr       = 5'b00011;
  localparam logic [4:0] CuStop      = 5'b11111;

  function automatic logic [7:0] boot_word(input int unsigned idx);
    logic [7:0] w;
    case (idx)
      0:       w = {CuLda, 5'b00001};
      1:       w = {CuLongBegin, CuCsl};
      2:       w = {CuLongBegin, CuShr};
      3:       w = {CuAdd, 5'b00010};
      4:       w = {CuSta, 5'b00001};
      5:       w = {CuBan, 5'b00001};
      6:       w = {CuJmp, 5'b01000};
      7:       w = {CuLongBegin, CuCla};
      8:       w = {CuLongBegin, CuStop};
      default: w = 8'h00;
    endcase
    return w;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DW'(boot_word(i));
      end
    end else if (ld_wr) begin
      mem_q[ld_ad_i[IW-1:0]] <= ld_data_i;
    end
  end
`else
  // Contents survive reset; the program must be loaded before fetching.
  always_ff @(posedge clk_i) begin
    if (ld_wr) begin
      mem_q[ld_ad_i[IW-1:0]] <= ld_data_i;
    end
  end
`endif

  assign out_o       = out_q;
  assign out_valid_o = out_valid_q;
  assign fault_o     = fault_q;
  assign ld_err_o    = ld_err_q;
  assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_imem_sync.sv
module tb_imem_sync;

  localparam int Depth = 32;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [7:0]  fetch_ad;
  logic        fetch_ready;
  logic [7:0]  out;
  logic        out_valid;
  logic        fault;
  logic        ld_en;
  logic [7:0]  ld_ad;
  logic [7:0]  ld_data;
  logic        ld_err;
  logic [15:0] fetch_cnt;

  imem_sync #(
    .DW   (8),
    .AW   (8),
    .DEPTH(Depth)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .fetch_req_i  (fetch_req),
    .fetch_ad_i   (fetch_ad),
    .fetch_ready_o(fetch_ready),
    .out_o        (out),
    .out_valid_o  (out_valid),
    .fault_o      (fault),
    .ld_en_i      (ld_en),
    .ld_ad_i      (ld_ad),
    .ld_data_i    (ld_data),
    .ld_err_o     (ld_err),
    .fetch_cnt_o  (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: expected responses are queued with the cycle on which they are due.
  typedef struct {
    int         due;
    logic [7:0] data;
    logic       oor;
  } rsp_t;

  rsp_t        rq[$];
  logic [7:0]  mm [Depth];
  int          cyc = 0;
  logic [15:0] m_cnt = 16'h0;
  logic        m_ld_err = 1'b0;
  logic [7:0]  m_last = 8'h00;
  bit          chk_en = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        rq.delete();
        m_cnt    = 16'h0;
        m_ld_err = 1'b0;
        m_last   = 8'h00;
`ifdef IMEM_BOOT_PROG_EN
        for (int i = 0; i < Depth; i++) mm[i] = 8'h00;
        mm[0] = 8'h21; mm[1] = 8'hE2; mm[2] = 8'hE3; mm[3] = 8'h42; mm[4] = 8'h61;
        mm[5] = 8'h81; mm[6] = 8'hA8; mm[7] = 8'hE1; mm[8] = 8'hFF;
`endif
      end else begin
        if (fetch_req && !ld_en) begin
          rsp_t r;
          r.due  = cyc + 2;
          r.oor  = (int'(fetch_ad) >= Depth);
          r.data = r.oor ? 8'h00 : mm[int'(fetch_ad)];
          rq.push_back(r);
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        m_ld_err = ld_en && (int'(ld_ad) >= Depth);
        if (ld_en && int'(ld_ad) < Depth) mm[int'(ld_ad)] = ld_data;
      end
      cyc++;
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        bit   exp_v;
        logic exp_f;
        exp_v = (rq.size() > 0) && (rq[0].due == cyc);
        exp_f = 1'b0;
        if (exp_v) begin
          m_last = rq[0].data;
          exp_f  = rq[0].oor;
          void'(rq.pop_front());
        end
        chk("fetch_ready", 32'(fetch_ready), 32'(!ld_en && !rst));
        chk("out_valid", 32'(out_valid), 32'(exp_v));
        chk("out", 32'(out), 32'(m_last));
        chk("fault", 32'(fault), 32'(exp_f));
        chk("ld_err", 32'(ld_err), 32'(m_ld_err));
        chk("fetch_cnt", 32'(fetch_cnt), 32'(m_cnt));
      end
    end
  end

  task automatic drive(input logic r, input logic fr, input logic [7:0] fa,
                       input logic le, input logic [7:0] la, input logic [7:0] ldat);
    @(posedge clk);
    #2;
    rst = r; fetch_req = fr; fetch_ad = fa; ld_en = le; ld_ad = la; ld_data = ldat;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    rst = 1'b1; fetch_req = 1'b0; fetch_ad = 8'h00;
    ld_en = 1'b0; ld_ad = 8'h00; ld_data = 8'h00;

    // Reset, then load and fetch a single word.
    drive(1'b0, 1'b0, 8'h00, 1'b1, 8'd3, 8'hA5);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 32'h0);
    chk("rst out", 32'(out), 32'h0);
    chk("rst fetch_cnt", 32'(fetch_cnt), 32'h0);
    chk("rst fault", 32'(fault), 32'h0);
    drive(1'b0, 1'b1, 8'd3, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk("t1 fetch_ready", 32'(fetch_ready), 32'h1);
    idle();
    @(negedge clk);
    chk("t1 latency no early valid", 32'(out_valid), 32'h0);
    idle();
    @(negedge clk);
    chk("t1 out", 32'(out), 32'hA5);
    chk("t1 out_valid", 32'(out_valid), 32'h1);
    chk("t1 fetch_cnt", 32'(fetch_cnt), 32'h1);

    // Back-to-back fetches.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 8'(i), 8'(8'h10 + i));
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 8'(i), 1'b0, 8'h00, 8'h00);
      if (i == 3) begin
        @(negedge clk);
        chk("b2b out[1]", 32'(out), 32'h11);
      end
    end
    idle();
    @(negedge clk);
    chk("b2b out[2]", 32'(out), 32'h12);
    chk("b2b valid[2]", 32'(out_valid), 32'h1);
    idle();
    @(negedge clk);
    chk("b2b out[3]", 32'(out), 32'h13);
    chk("b2b fetch_cnt", 32'(fetch_cnt), 32'h4);
    idle();
    @(negedge clk);
    chk("b2b valid drops", 32'(out_valid), 32'h0);

    // Load/fetch contention: the load wins, the fetch is held and taken next cycle.
    drive(1'b0, 1'b1, 8'd5, 1'b1, 8'd5, 8'h3C);
    @(negedge clk);
    chk("cont fetch_ready", 32'(fetch_ready), 32'h0);
    drive(1'b0, 1'b1, 8'd5, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk("cont retry ready", 32'(fetch_ready), 32'h1);
    idle();
    idle();
    @(negedge clk);
    chk("cont out", 32'(out), 32'h3C);
    chk("cont fetch_cnt", 32'(fetch_cnt), 32'h5);

    // Range errors.
    drive(1'b0, 1'b0, 8'h00, 1'b1, 8'd8, 8'h77);
    drive(1'b0, 1'b1, 8'd32, 1'b0, 8'h00, 8'h00);
    idle();
    idle();
    @(negedge clk);
    chk("oor out", 32'(out), 32'h0);
    chk("oor fault", 32'(fault), 32'h1);
    chk("oor out_valid", 32'(out_valid), 32'h1);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 8'd40, 8'hFF);
    @(negedge clk);
    chk("oor fault pulse", 32'(fault), 32'h0);
    idle();
    @(negedge clk);
    chk("ld_err pulse", 32'(ld_err), 32'h1);
    idle();
    @(negedge clk);
    chk("ld_err clears", 32'(ld_err), 32'h0);
    drive(1'b0, 1'b1, 8'd8, 1'b0, 8'h00, 8'h00);
    idle();
    idle();
    @(negedge clk);
    chk("word 8 intact", 32'(out), 32'h77);

    // Reset on the cycle after an accept loses the fetch.
    drive(1'b0, 1'b1, 8'd3, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    idle();
    @(negedge clk);
    chk("midrst out_valid", 32'(out_valid), 32'h0);
    chk("midrst out", 32'(out), 32'h0);
    chk("midrst fetch_cnt", 32'(fetch_cnt), 32'h0);

`ifdef IMEM_BOOT_PROG_EN
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b1, 8'd0, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b1, 8'd6, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b1, 8'd20, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk("boot word 0", 32'(out), 32'h21);
    idle();
    @(negedge clk);
    chk("boot word 6", 32'(out), 32'hA8);
    idle();
    @(negedge clk);
    chk("boot word 20", 32'(out), 32'h00);
    chk("boot word 20 fault", 32'(fault), 32'h0);
`endif

    idle();
    idle();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
